fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 9 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-side constants and the fetch queue entry layout.
package riscv_pkg;
    localparam logic [31:0] NOP_INST             = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched instructions with flush and same-cycle push+pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding memory request, redirect discard tracking
// and a small instruction queue feeding decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_f,
    output logic [31:0] INST_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC4_F
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]  fetch_pc, pend_addr, held_addr;
    logic         outstanding, req_hold, stale;
    logic [1:0]   disc_cnt;
    logic         hs, rsp, push, pop, empty, disc_inc, disc_dec;
    logic         q_full_unused, unused_rpc;
    logic [CW-1:0] count;
    logic [CW:0]  occ;
    fetch_entry_t head;

    // A returning response becomes a queue entry, so it still counts toward occupancy.
    assign occ        = {1'b0, count} + (CW+1)'(outstanding) - (CW+1)'(pop);
    assign imem_req   = !rst && (req_hold || ((!outstanding || imem_rvalid) && occ < (CW+1)'(QDEPTH)));
    assign imem_addr  = req_hold ? held_addr : fetch_pc;
    assign hs         = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && outstanding;
    assign push       = rsp && !redirect && disc_cnt == 2'd0;
    assign pop        = valid_f && !stall && !redirect;
    assign disc_inc   = (redirect && outstanding && !imem_rvalid) || (hs && (redirect || stale));
    assign disc_dec   = rsp && disc_cnt != 2'd0;
    assign valid_f    = !empty;
    assign INST_F     = empty ? NOP_INST : head.inst;
    assign PC_F       = empty ? 32'd0 : head.pc;
    assign PC4_F      = empty ? 32'd0 : head.pc + 32'd4;
    assign unused_rpc = ^redirect_pc[1:0];

    // A request already on the bus keeps its address across a redirect; stale marks it for discard.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            pend_addr   <= '0;
            held_addr   <= '0;
            outstanding <= 1'b0;
            req_hold    <= 1'b0;
            stale       <= 1'b0;
            disc_cnt    <= '0;
        end else begin
            fetch_pc    <= redirect ? {redirect_pc[31:2], 2'b00} : (hs && !stale) ? fetch_pc + 32'd4 : fetch_pc;
            outstanding <= hs || (outstanding && !imem_rvalid);
            pend_addr   <= hs ? imem_addr : pend_addr;
            held_addr   <= imem_addr;
            req_hold    <= imem_req && !imem_gnt;
            stale       <= imem_req && !imem_gnt && (redirect || stale);
            disc_cnt    <= disc_cnt + 2'(disc_inc) - 2'(disc_dec);
        end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ('{pc: pend_addr, inst: imem_rdata}),
        .rdata (head),
        .full  (q_full_unused),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table for request/valid timing plus a PC scoreboard fed by the
// expected program order; a second instance checks PC wrap-around.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic clk = 0, rst = 0, stall = 0, redirect = 0, gnt = 1, lat2 = 0;
    logic [31:0] redirect_pc = 0;
    logic imem_req, imem_rvalid, valid_f;
    logic [31:0] imem_addr, imem_rdata, INST_F, PC_F, PC4_F;
    logic rv1, rv2;
    logic [31:0] ra1, ra2;

    logic w_req, w_valid, w_rv;
    logic [31:0] w_addr, w_inst, w_pc, w_pc4, w_ra;

    int n_checks = 0, n_fail = 0, consumed = 0, w_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    logic [31:0] w_exp = 32'hFFFF_FFFC;

    typedef struct {
        logic stall, gnt, redirect;
        logic [31:0] rpc;
        logic req;
        logic [31:0] addr;
        logic valid;
    } vec_t;

    vec_t t1[22];
    vec_t t2[10];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .valid_f(valid_f), .INST_F(INST_F), .PC_F(PC_F), .PC4_F(PC4_F)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1), .imem_rvalid(w_rv),
        .imem_rdata(w_ra ^ K), .valid_f(w_valid), .INST_F(w_inst), .PC_F(w_pc), .PC4_F(w_pc4)
    );

    // Memory model: response one (or two, with lat2) cycles after grant, data = addr ^ K.
    always @(posedge clk or posedge rst)
        if (rst) begin
            rv1 <= 0; rv2 <= 0; ra1 <= 0; ra2 <= 0; w_rv <= 0; w_ra <= 0;
        end else begin
            rv1 <= imem_req && gnt;
            ra1 <= imem_addr;
            rv2 <= rv1;
            ra2 <= ra1;
            w_rv <= w_req;
            w_ra <= w_addr;
        end
    assign imem_rvalid = lat2 ? rv2 : rv1;
    assign imem_rdata  = (lat2 ? ra2 : ra1) ^ K;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reload(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(base + 32'(i * 4));
    endtask

    function automatic vec_t mk(input logic s, g, r, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic v);
        vec_t t;
        t.stall = s; t.gnt = g; t.redirect = r; t.rpc = rpc;
        t.req = req; t.addr = addr; t.valid = v;
        return t;
    endfunction

    task automatic run(input vec_t t, input int idx);
        stall = t.stall;
        gnt = t.gnt;
        redirect = t.redirect;
        redirect_pc = t.rpc;
        if (t.redirect) reload({t.rpc[31:2], 2'b00});
        @(negedge clk);
        check32($sformatf("req[%0d]", idx), 32'(imem_req), 32'(t.req));
        if (t.req) check32($sformatf("addr[%0d]", idx), imem_addr, t.addr);
        check32($sformatf("valid[%0d]", idx), 32'(valid_f), 32'(t.valid));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check32({tag, "_req"}, 32'(imem_req), 32'd0);
        check32({tag, "_valid"}, 32'(valid_f), 32'd0);
        check32({tag, "_inst"}, INST_F, 32'h0000_0013);
        check32({tag, "_pc"}, PC_F, 32'd0);
        check32({tag, "_pc4"}, PC4_F, 32'd0);
        check32({tag, "_wreq"}, 32'(w_req), 32'd0);
    endtask

    // Scoreboard: every consumed head must be the next PC in expected program order.
    always @(negedge clk)
        if (!rst && valid_f && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got pc %h expected none", PC_F);
            end else begin
                sb_e = exp_q.pop_front();
                check32("sb_pc", PC_F, sb_e);
                check32("sb_inst", INST_F, sb_e ^ K);
                check32("sb_pc4", PC4_F, sb_e + 32'd4);
                consumed++;
            end
        end

    always @(negedge clk)
        if (rst) w_exp = 32'hFFFF_FFFC;
        else if (w_valid) begin
            check32("wrap_pc", w_pc, w_exp);
            check32("wrap_pc4", w_pc4, w_exp + 32'd4);
            check32("wrap_inst", w_inst, w_exp ^ K);
            w_exp = w_exp + 32'd4;
            w_seen++;
        end

    initial begin
        t1[0]  = mk(0, 1, 0, 0, 1, 32'h000, 0);
        t1[1]  = mk(0, 1, 0, 0, 1, 32'h004, 0);
        t1[2]  = mk(0, 1, 0, 0, 1, 32'h008, 1);
        t1[3]  = mk(0, 1, 0, 0, 1, 32'h00C, 1);
        for (int i = 4; i < 9; i++) t1[i] = mk(1, 1, 0, 0, 0, 0, 1);
        t1[9]  = mk(0, 1, 0, 0, 1, 32'h010, 1);
        t1[10] = mk(0, 1, 1, 32'h103, 0, 0, 1);
        t1[11] = mk(0, 1, 0, 0, 1, 32'h100, 0);
        t1[12] = mk(0, 1, 0, 0, 1, 32'h104, 0);
        t1[13] = mk(0, 1, 0, 0, 1, 32'h108, 1);
        t1[14] = mk(0, 0, 0, 0, 1, 32'h10C, 1);
        t1[15] = mk(0, 0, 0, 0, 1, 32'h10C, 1);
        t1[16] = mk(0, 0, 0, 0, 1, 32'h10C, 0);
        t1[17] = mk(0, 0, 1, 32'h200, 1, 32'h10C, 0);
        t1[18] = mk(0, 1, 0, 0, 1, 32'h10C, 0);
        t1[19] = mk(0, 1, 0, 0, 1, 32'h200, 0);
        t1[20] = mk(0, 1, 0, 0, 1, 32'h204, 0);
        t1[21] = mk(0, 1, 0, 0, 1, 32'h208, 1);

        t2[0] = mk(0, 1, 0, 0, 1, 32'h000, 0);
        t2[1] = mk(0, 1, 0, 0, 0, 0, 0);
        t2[2] = mk(0, 1, 0, 0, 1, 32'h004, 0);
        t2[3] = mk(0, 1, 0, 0, 0, 0, 1);
        t2[4] = mk(0, 1, 0, 0, 1, 32'h008, 0);
        t2[5] = mk(0, 1, 1, 32'h103, 0, 0, 1);
        t2[6] = mk(0, 1, 0, 0, 1, 32'h100, 0);
        t2[7] = mk(0, 1, 0, 0, 0, 0, 0);
        t2[8] = mk(0, 1, 0, 0, 1, 32'h104, 0);
        t2[9] = mk(0, 1, 0, 0, 0, 0, 1);

        reload(32'h0);
        #2 rst = 1;
        repeat (2) @(posedge clk);
        reset_checks("rst0");
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 22; i++) run(t1[i], i);

        // Reset mid-stream with entries queued, then replay with a two-cycle memory.
        rst = 1;
        lat2 = 1;
        stall = 0;
        gnt = 1;
        redirect = 0;
        reload(32'h0);
        reset_checks("rst1");
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 10; i++) run(t2[i], 100 + i);

        check32("consumed", 32'(consumed), 32'd9);
        check32("wrap_seen", 32'(w_seen > 10), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
